// File: rtl/frame_rd_ctrl_pkg.sv
// Shared definitions for the frame read path: default resolution, background
// colour and the RGB565 -> RGB888 expansion used by display and UART paths.
package frame_rd_ctrl_pkg;

  localparam int          H_DISP_DEF   = 800;
  localparam int          V_DISP_DEF   = 480;
  localparam logic [23:0] BG_COLOR_DEF = 24'h000000;

  // Widen each channel by replicating its MSBs into the new low bits.
  function automatic logic [23:0] rgb565_to_888_f(input logic [15:0] pix);
    return {pix[15:11], pix[15:13], pix[10:5], pix[10:9], pix[4:0], pix[4:2]};
  endfunction

endpackage

// File: rtl/frame_rd_ctrl_rgb565_to_888.sv
// Combinational RGB565 to RGB888 expander, shared with the UART write path.
module rgb565_to_888
  import frame_rd_ctrl_pkg::*;
(
  input  logic [15:0] rgb565,
  output logic [23:0] rgb888
);

  assign rgb888 = rgb565_to_888_f(rgb565);

endmodule

// File: rtl/frame_rd_ctrl.sv
// Pixel source for the display timing controller: streams a double-buffered
// RGB565 image from RAM at a fixed screen offset, background elsewhere.
module frame_rd_ctrl
  import frame_rd_ctrl_pkg::*;
#(
  parameter int          H_DISP   = H_DISP_DEF,
  parameter int          V_DISP   = V_DISP_DEF,
  parameter int          IMG_X    = 272,
  parameter int          IMG_Y    = 176,
  parameter int          IMG_W    = 256,
  parameter int          IMG_H    = 128,
  parameter int          ADDR_W   = 16,
  parameter logic [23:0] BG_COLOR = BG_COLOR_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Data_Req,
  input  logic              VGA_VS,
  input  logic              buf_sel,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [15:0]       ram_rd_data,
  output logic [23:0]       DATA,
  output logic              frame_done,
  output logic              cur_buf
);

  localparam int                IMG_PIX   = IMG_W * IMG_H;
  localparam logic [10:0]       X_LO      = 11'(IMG_X);
  localparam logic [10:0]       X_HI      = 11'(IMG_X + IMG_W);
  localparam logic [10:0]       Y_LO      = 11'(IMG_Y);
  localparam logic [10:0]       Y_HI      = 11'(IMG_Y + IMG_H);
  localparam logic [10:0]       X_LAST    = 11'(H_DISP - 1);
  localparam logic [10:0]       Y_LAST    = 11'(V_DISP - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(IMG_PIX - 1);
  localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(IMG_PIX);

  logic [10:0]       x_cnt_r;
  logic [10:0]       y_cnt_r;
  logic [ADDR_W-1:0] ptr_r;
  logic              vs_d_r;

  logic              in_win_s;
  logic              consume_s;
  logic              eol_s;
  logic              eof_s;
  logic              resync_s;
  logic [ADDR_W-1:0] ptr_next_s;
  logic [ADDR_W-1:0] base_s;
  logic [23:0]       pix_s;

  // Window decode, frame events and lookahead read address.
  always_comb begin
    in_win_s   = 1'b0;
    consume_s  = 1'b0;
    eol_s      = 1'b0;
    eof_s      = 1'b0;
    resync_s   = 1'b0;
    ptr_next_s = '0;
    base_s     = '0;
    if ((x_cnt_r >= X_LO) && (x_cnt_r < X_HI) && (y_cnt_r >= Y_LO) && (y_cnt_r < Y_HI)) begin
      in_win_s = 1'b1;
    end else begin
      in_win_s = 1'b0;
    end
    consume_s = Data_Req & in_win_s;
    eol_s     = (x_cnt_r == X_LAST);
    eof_s     = Data_Req & eol_s & (y_cnt_r == Y_LAST);
    resync_s  = vs_d_r & ~VGA_VS;
    // Wrapping at the last image pixel keeps ptr inside the image.
    if (ptr_r == PTR_LAST) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = ptr_r + ADDR_W'(1);
    end
    if (cur_buf) begin
      base_s = BUF1_BASE;
    end else begin
      base_s = '0;
    end
  end

  // Fetch one pixel ahead while consuming so RAM latency is hidden.
  assign ram_rd_addr = base_s + (consume_s ? ptr_next_s : ptr_r);

  rgb565_to_888 u_expand (
    .rgb565 (ram_rd_data),
    .rgb888 (pix_s)
  );

  assign DATA = in_win_s ? pix_s : BG_COLOR;

  // Raster position, image pointer and per-frame buffer latch.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_cnt_r    <= 11'd0;
      y_cnt_r    <= 11'd0;
      ptr_r      <= '0;
      vs_d_r     <= 1'b0;
      cur_buf    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vs_d_r     <= VGA_VS;
      frame_done <= eof_s;
      if (resync_s || eof_s) begin
        x_cnt_r <= 11'd0;
        y_cnt_r <= 11'd0;
        ptr_r   <= '0;
        cur_buf <= buf_sel;
      end else if (Data_Req) begin
        if (eol_s) begin
          x_cnt_r <= 11'd0;
          y_cnt_r <= y_cnt_r + 11'd1;
        end else begin
          x_cnt_r <= x_cnt_r + 11'd1;
        end
        if (consume_s) begin
          ptr_r <= ptr_next_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_rd_ctrl.sv
// Scoreboard bench for frame_rd_ctrl on a scaled-down screen and image.
module tb_frame_rd_ctrl;

  localparam int          H    = 40;
  localparam int          V    = 24;
  localparam int          IX   = 12;
  localparam int          IY   = 8;
  localparam int          IW   = 16;
  localparam int          IH   = 8;
  localparam int          AW   = 8;
  localparam int          PIX  = IW * IH;
  localparam int          HB   = 8;
  localparam logic [23:0] BG   = 24'h0A0B0C;
  localparam int          RX   = 20;
  localparam int          RY   = 12;

  logic          clk = 1'b0;
  logic          Reset, Data_Req, VGA_VS, buf_sel;
  logic [AW-1:0] ram_rd_addr;
  logic [15:0]   ram_rd_data;
  logic [23:0]   DATA;
  logic          frame_done, cur_buf;

  logic [15:0]   mem [0:(1<<AW)-1];
  logic [23:0]   sb [$];

  int  n_checks = 0;
  int  n_errors = 0;
  bit  chk_en = 1'b0;
  bit  recovering = 1'b0;
  bit  rst_req = 1'b0;
  int  rst_cnt = 0;
  int  exp_buf = 0;
  int  consumed = 0;
  int  exp_addr = 0;
  int  drv_x = 0;
  int  drv_y = 0;
  bit  drv_eof = 1'b0;
  bit  last_eof = 1'b0;
  bit  last_vs = 1'b1;
  bit  last_vs_old = 1'b1;
  bit  fd_pipe = 1'b0;

  frame_rd_ctrl #(
    .H_DISP(H), .V_DISP(V), .IMG_X(IX), .IMG_Y(IY), .IMG_W(IW), .IMG_H(IH),
    .ADDR_W(AW), .BG_COLOR(BG)
  ) dut (
    .Clk(clk), .Reset(Reset), .Data_Req(Data_Req), .VGA_VS(VGA_VS),
    .buf_sel(buf_sel), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .DATA(DATA), .frame_done(frame_done), .cur_buf(cur_buf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_rd_data <= mem[ram_rd_addr];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [23:0] expand(input logic [15:0] p);
    int r, g, b;
    r = int'(p) >> 11;
    g = (int'(p) >> 5) & 63;
    b = int'(p) & 31;
    r = (r << 3) | (r >> 2);
    g = (g << 2) | (g >> 4);
    b = (b << 3) | (b >> 2);
    return 24'((r << 16) | (g << 8) | b);
  endfunction

  function automatic bit in_img(input int x, input int y);
    return (x >= IX) && (x < IX + IW) && (y >= IY) && (y < IY + IH);
  endfunction

  // One pixel-clock of stimulus; first accounts for what the last edge did.
  task automatic drive(input bit req, input bit vs, input int x, input int y);
    bit inw;
    @(posedge clk);
    if (last_eof || (last_vs_old && !last_vs)) begin
      exp_buf  = int'(buf_sel);
      consumed = 0;
      if (recovering && !last_eof) begin
        recovering = 1'b0;
        chk_en     = 1'b1;
      end
    end
    if (rst_req) begin
      Reset      = 1'b1;
      chk_en     = 1'b0;
      recovering = 1'b1;
      rst_req    = 1'b0;
      rst_cnt    = 2;
    end else if (rst_cnt > 0) begin
      rst_cnt--;
    end
    #1;
    if (rst_cnt == 0) Reset = 1'b0;
    Data_Req = req;
    VGA_VS   = vs;
    drv_x    = x;
    drv_y    = y;
    inw      = req && in_img(x, y);
    drv_eof  = req && (x == H - 1) && (y == V - 1);
    if (chk_en && req) begin
      if (inw) sb.push_back(expand(mem[exp_buf * PIX + (y - IY) * IW + (x - IX)]));
      else     sb.push_back(BG);
    end
    exp_addr    = exp_buf * PIX + ((consumed + int'(inw)) % PIX);
    consumed    = consumed + int'(inw);
    last_eof    = drv_eof;
    last_vs_old = last_vs;
    last_vs     = vs;
  endtask

  task automatic run_frame(input int n);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (n == 0 && y == IY + 2 && x == IX + 5) repeat (3) drive(1'b0, 1'b1, x, y);
        if (n == 0 && y == V / 2 && x == 0) buf_sel = 1'b1;
        if (n == 1 && y == V / 2 && x == 0) buf_sel = 1'b0;
        if (n == 1 && y == RY && x == RX) rst_req = 1'b1;
        drive(1'b1, 1'b1, x, y);
      end
      repeat (HB) drive(1'b0, 1'b1, 0, 0);
    end
    repeat (2) drive(1'b0, 1'b1, 0, 0);
    repeat (2) drive(1'b0, 1'b0, 0, 0);
    repeat (2) drive(1'b0, 1'b1, 0, 0);
  endtask

  // Compare every cycle against the bench-side expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check_value("rd_addr", 32'(ram_rd_addr), 32'(exp_addr));
      check_value("cur_buf", 32'(cur_buf), 32'(exp_buf));
      check_value("frame_done", 32'(frame_done), 32'(fd_pipe));
      if (Data_Req) begin
        if (sb.size() == 0) begin
          check_value("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          check_value("pixel", 32'(DATA), 32'(sb.pop_front()));
        end
        if (drv_x == IX && drv_y == IY && exp_buf == 1)
          check_value("colour_F81F", 32'(DATA), 32'h00FF00FF);
      end
    end
    fd_pipe = Data_Req && drv_eof;
  end

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = 16'(a);
    mem[PIX] = 16'hF81F;
    Reset    = 1'b1;
    Data_Req = 1'b0;
    VGA_VS   = 1'b1;
    buf_sel  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    Reset = 1'b0;
    @(negedge clk);
    check_value("rst_data", 32'(DATA), 32'(BG));
    check_value("rst_frame_done", 32'(frame_done), 32'd0);
    check_value("rst_cur_buf", 32'(cur_buf), 32'd0);
    check_value("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
    chk_en = 1'b1;
    run_frame(0);
    run_frame(1);
    run_frame(2);
    repeat (2) drive(1'b0, 1'b1, 0, 0);
    @(negedge clk);
    check_value("recovered", 32'(chk_en), 32'd1);
    check_value("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_rd_ctrl.md
Name: frame_rd_ctrl

Overview:
- Pixel-source stage directly upstream of the VGA/TFT timing controller.
- Answers that controller's data-request strobe with the 24-bit pixel for the current screen position, in the same cycle.
- Reads an IMG_W x IMG_H RGB565 image from a synchronous-read dual-port RAM that the UART path fills, and places it at a fixed screen offset. Pixels outside the image get a background colour.
- Supports double buffering: the buffer choice is latched once per frame, so a frame is never displayed torn.

Parameters:
- H_DISP, 800, active pixels per line.
- V_DISP, 480, active lines per frame.
- IMG_X, 272, image left column on screen.
- IMG_Y, 176, image top line on screen.
- IMG_W, 256, image width in pixels.
- IMG_H, 128, image height in lines.
- ADDR_W, 16, RAM address width; must satisfy 2*IMG_W*IMG_H <= 2^ADDR_W.
- BG_COLOR, 24'h000000, RGB888 value driven outside the image window.

Ports:
- Clk  in  1  pixel clock, same clock as the timing controller.
- Reset  in  1  asynchronous, active-high reset.
- Data_Req  in  1  request strobe from the timing controller; high for each active pixel, in raster order.
- VGA_VS  in  1  vertical sync from the timing controller, active low; used only for resync.
- buf_sel  in  1  buffer to display; sampled at frame start.
- ram_rd_addr  out  ADDR_W  RAM read address, combinational.
- ram_rd_data  in  16  RAM read data (RGB565), valid one cycle after the address.
- DATA  out  24  RGB888 pixel to the timing controller, combinational.
- frame_done  out  1  one-cycle pulse after the last active pixel of a frame.
- cur_buf  out  1  buffer currently being displayed.

Behaviour:
- Registers:
  - x_cnt [10:0] and y_cnt [10:0]: position of the next requested pixel.
  - ptr [ADDR_W-1:0]: image offset of the next image pixel.
  - cur_buf.
  - frame_done.
  - vs_d: one-cycle delay of VGA_VS.
- Reset values: all registers 0, so frame_done = 0 and cur_buf = 0. With x_cnt = y_cnt = 0, DATA = BG_COLOR unless IMG_X = IMG_Y = 0.
- Window test: in_win = (IMG_X <= x_cnt < IMG_X+IMG_W) && (IMG_Y <= y_cnt < IMG_Y+IMG_H), decoded from registered counters.
- Consume: consume = Data_Req && in_win.
- Address generation:
  - base = cur_buf ? IMG_W*IMG_H : 0.
  - ram_rd_addr = base + (consume ? ptr+1 : ptr).
  - This lookahead makes ram_rd_data equal the next image pixel in the cycle that pixel is requested. The result is zero-bubble streaming across an image line and across line boundaries.
- Data path:
  - DATA = in_win ? {R5,R5[4:2], G6,G6[5:4], B5,B5[4:2]} : BG_COLOR.
  - The expansion is MSB replication.
  - DATA is not registered; the timing controller registers it.
- Counter advance on Data_Req:
  - x_cnt increments.
  - At x_cnt = H_DISP-1: x_cnt wraps to 0 and y_cnt increments.
  - At y_cnt = V_DISP-1 with x_cnt = H_DISP-1 (end of frame):
    - y_cnt wraps to 0.
    - ptr clears to 0.
    - frame_done pulses on the next cycle.
    - cur_buf loads buf_sel.
- ptr: increments on consume, except at end of frame where the clear takes priority. ptr never exceeds IMG_W*IMG_H-1 within a frame.
- Data_Req low: all counters hold. ram_rd_addr stays at base+ptr, so the prefetch is stable through blanking.
- Resync on VS falling edge (vs_d = 1, VGA_VS = 0):
  - x_cnt, y_cnt and ptr clear, and cur_buf loads buf_sel.
  - frame_done does not pulse.
  - This recovers alignment after a reset mid-frame or a dropped request. If it coincides with an end-of-frame event, the result is identical.
- Reset mid-frame: all state returns to reset values immediately. Output is garbage until the next VS falling edge, after which the output is exact.
- buf_sel changes mid-frame have no effect until the next frame start.
- Latency: 0 cycles from Data_Req to DATA, given the RAM's 1-cycle read latency.

Decomposition:
- Shared package (or include file, alongside the resolution defines) holds:
  - H_DISP / V_DISP defaults;
  - the RGB565-to-RGB888 expansion function;
  - the BG_COLOR constant.
- One sub-module is natural: rgb565_to_888, purely combinational, reusable by the UART write path.
- Counters and address logic stay in frame_rd_ctrl.

Test Plan:
1. Reset, then one full frame of Data_Req bursts (H_DISP high, 256 low, per line) with RAM preloaded so mem[a] = a[15:0]. The first in-window pixel at (272,176) must give DATA = expand(16'h0000). Pixel (273,176) must give expand(16'h0001). The last in-window pixel at (527,303) must give expand(16'h7FFF). All other pixels must be 24'h000000.
2. Hold Data_Req low for 3 cycles in the middle of an image line. ram_rd_addr must stay constant, and the next request must return the correct next pixel with no skip or repeat.
3. Drive buf_sel = 1 at mid-frame. The current frame must keep its addresses in 0..32767. The next frame's first image pixel must read address 32768, and cur_buf must equal 1.
4. End of frame. frame_done must be high for exactly 1 cycle after request (799,479). The next request must be treated as (0,0), with ptr = 0.
5. Assert Reset at pixel (400,200), then deassert and keep streaming. After the next VS falling edge, frame output must match scenario 1 exactly.
6. Check colour expansion with RAM word 16'hF81F. DATA must be 24'hFF00FF.
